midi_note_rx: RTL and testbench

- Serial receive front-end for the music core. Accepts 8N1 UART frames on one input pin and assembles two-byte note commands (note byte, then velocity byte).
- Presents each completed command to the tone/sequencer logic through a single-entry valid/ready holding register.
- It is the device-side receiver for the note stream that an external host transmits into the chip.

---
 rtl/midi_note_rx.sv | 158 +++++++++++++++
 tb/tb_midi_note_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_rx.sv
// midi_note_rx: UART receiver assembling note/velocity byte pairs into held commands; define MIDI_NOTE_RX_PARITY_EN for 8E1 frames
module midi_note_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [6:0] cmd_note,
  output logic [6:0] cmd_vel,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MIDI_NOTE_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic [7:0]             byte_q;
  logic                   byte_vld_q;
  logic                   frame_err_q;
  logic                   busy_q;
  logic                   par_bad;
  logic                   pend_q, pend_d;
  logic [6:0]             pnote_q, pnote_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [6:0]             cmd_note_q, cmd_note_d;
  logic [6:0]             cmd_vel_q, cmd_vel_d;
  logic                   overrun_q, overrun_d;
  logic                   cmd_new, hold, load;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous rx pin into the clk domain; idle-high reset avoids a false start.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], rx};

`ifdef MIDI_NOTE_RX_PARITY_EN
  logic par_q;
  assign par_bad = par_q;
  // Even parity: XOR of data and parity bit must be zero; latched for the stop-bit decision.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= 1'b0;
    else if (state_q == PARITY && cnt_q == LAST) par_q <= ^shift_q ^ rxs;
`else
  assign par_bad = 1'b0;
`endif

  // Bit-level FSM: find mid-start, sample mid-bit LSB first, then judge the frame at the stop bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (!rxs) begin
          state_q <= START;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
        START: if (cnt_q == HALF) begin
          cnt_q   <= '0;
          bit_q   <= '0;
          state_q <= rxs ? IDLE : DATA;
          busy_q  <= !rxs;
        end
        DATA: if (cnt_q == LAST) begin
          shift_q <= {rxs, shift_q[7:1]};
          bit_q   <= bit_q + 1'b1;
`ifdef MIDI_NOTE_RX_PARITY_EN
          if (bit_q == 3'd7) state_q <= PARITY;
`else
          if (bit_q == 3'd7) state_q <= STOP;
`endif
        end
`ifdef MIDI_NOTE_RX_PARITY_EN
        PARITY: if (cnt_q == LAST) state_q <= STOP;
`endif
        STOP: if (cnt_q == LAST) begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          byte_q      <= shift_q;
          byte_vld_q  <= rxs && !par_bad;
          frame_err_q <= !rxs || par_bad;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end

  // Byte assembler and single-entry command holding register with overrun detection.
  always_comb begin
    cmd_new     = byte_vld_q && !byte_q[7] && pend_q;
    pend_d      = frame_err_q ? 1'b0 : (byte_vld_q ? byte_q[7] : pend_q);
    pnote_d     = (byte_vld_q && byte_q[7]) ? byte_q[6:0] : pnote_q;
    hold        = cmd_valid_q && !cmd_ready;
    load        = cmd_new && !hold;
    cmd_valid_d = load || hold;
    cmd_note_d  = load ? pnote_q : cmd_note_q;
    cmd_vel_d   = load ? byte_q[6:0] : cmd_vel_q;
    overrun_d   = cmd_new && hold;
  end

  // Register assembler and command state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pnote_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_note_q  <= '0;
      cmd_vel_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pnote_q     <= pnote_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_note_q  <= cmd_note_d;
      cmd_vel_q   <= cmd_vel_d;
      overrun_q   <= overrun_d;
    end

  assign cmd_valid = cmd_valid_q;
  assign cmd_note  = cmd_note_q;
  assign cmd_vel   = cmd_vel_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_midi_note_rx.sv
// tb_midi_note_rx: directed and random UART byte streams checked against a byte-level command model
module tb_midi_note_rx;
  localparam int C = 87;
`ifdef MIDI_NOTE_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 11 : 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [6:0] cmd_note;
  logic [6:0] cmd_vel;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  midi_note_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_note(cmd_note), .cmd_vel(cmd_vel),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int busy_cnt = 0;
  logic [13:0] got[$];
  logic [13:0] exp_q[$];
  logic        mpend = 1'b0;
  logic [6:0]  mnote = '0;
  int          m_ferr = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [6:0]  pn = '0, pvl = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Observe outputs mid-cycle: collect transfers, pulse counts and hold stability.
  always @(negedge clk) begin
    if (!rst_n) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_note", cmd_note, pn);
        chk("hold_vel", cmd_vel, pvl);
      end
      if (cmd_valid && cmd_ready) got.push_back({cmd_note, cmd_vel});
      if (cmd_valid && !pv) rise_cyc = cyc;
      ferr_cnt += int'(frame_err);
      ovr_cnt  += int'(overrun);
      busy_cnt += int'(busy);
      pv = cmd_valid; pr = cmd_ready; pn = cmd_note; pvl = cmd_vel;
    end
  end

  task automatic model_byte(input logic [7:0] b, input logic bad);
    if (bad) begin
      mpend = 1'b0;
      m_ferr++;
    end else if (b[7]) begin
      mpend = 1'b1;
      mnote = b[6:0];
    end else if (mpend) begin
      exp_q.push_back({mnote, b[6:0]});
      mpend = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic pgood, input int gap);
    start_cyc = cyc;
    rx = 1'b0; tick(C);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(C); end
    if (PAR) begin rx = ^b ^ ~pgood; tick(C); end
    rx = stop; tick(C);
    rx = 1'b1;
    if (gap > 0) tick(gap);
    model_byte(b, !stop || (PAR && !pgood));
  endtask

  initial begin
    int base, f0, o0, b0, n;
    logic [7:0] b;
    logic stop, pg;
    tick(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_note", cmd_note, 0);
    chk("rst_vel", cmd_vel, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);

    base = got.size(); f0 = ferr_cnt;
    send_byte(8'h90, 1, 1, 0);
    send_byte(8'h64, 1, 1, C);
    chk("note_cnt", got.size(), base + 1);
    if (got.size() > base) chk("note_cmd", got[base], {7'h10, 7'h64});
    chk("note_lat_lo", rise_cyc >= start_cyc + (NB - 1) * C + C / 2, 1);
    chk("note_lat_hi", rise_cyc <= start_cyc + (NB - 1) * C + C / 2 + 8, 1);
    chk("note_ferr", ferr_cnt - f0, 0);

    base = got.size();
    send_byte(8'hBC, 1, 1, 0);
    send_byte(8'hC5, 1, 1, 0);
    send_byte(8'h20, 1, 1, C);
    send_byte(8'h33, 1, 1, C);
    chk("repl_cnt", got.size(), base + 1);
    if (got.size() > base) chk("repl_cmd", got[base], {7'h45, 7'h20});

    cmd_ready = 1'b0; o0 = ovr_cnt;
    send_byte(8'h81, 1, 1, 0);
    send_byte(8'h01, 1, 1, 0);
    send_byte(8'h82, 1, 1, 0);
    send_byte(8'h02, 1, 1, C);
    chk("bp_valid", cmd_valid, 1);
    chk("bp_note", cmd_note, 7'h01);
    chk("bp_vel", cmd_vel, 7'h01);
    chk("bp_ovr", ovr_cnt - o0, 1);
    base = got.size();
    cmd_ready = 1'b1;
    tick(4);
    chk("bp_xfer_cnt", got.size(), base + 1);
    if (got.size() > base) chk("bp_xfer", got[base], {7'h01, 7'h01});
    chk("bp_drop", cmd_valid, 0);

    base = got.size(); f0 = ferr_cnt;
    send_byte(8'h90, 0, 1, 2 * C);
    send_byte(8'h05, 1, 1, C);
    chk("frm_ferr", ferr_cnt - f0, 1);
    chk("frm_nocmd", got.size(), base);

    f0 = ferr_cnt; b0 = busy_cnt;
    rx = 1'b0; tick(26);
    rx = 1'b1; tick(C);
    chk("glitch_busy", busy_cnt > b0, 1);
    chk("glitch_idle", busy, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_nocmd", got.size(), base);

`ifdef MIDI_NOTE_RX_PARITY_EN
    f0 = ferr_cnt;
    send_byte(8'h90, 1, 1, 0);
    send_byte(8'h64, 1, 0, 2 * C);
    chk("par_ferr", ferr_cnt - f0, 1);
    chk("par_nocmd", got.size(), base);
    send_byte(8'h90, 1, 1, 0);
    send_byte(8'h64, 1, 1, C);
    chk("par_cnt", got.size(), base + 1);
    if (got.size() > base) chk("par_cmd", got[base], {7'h10, 7'h64});
`endif

    cmd_ready = 1'b0;
    send_byte(8'h83, 1, 1, 0);
    send_byte(8'h07, 1, 1, 0);
    send_byte(8'h90, 1, 1, 0);
    rx = 1'b0; tick(C);
    rx = 1'b0; tick(C);
    rx = 1'b1; tick(C);
    rx = 1'b0; tick(C / 2);
    chk("pre_rst_valid", cmd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", cmd_valid, 0);
    chk("arst_note", cmd_note, 0);
    chk("arst_vel", cmd_vel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ferr", frame_err, 0);
    chk("arst_ovr", overrun, 0);
    mpend = 1'b0;
    rx = 1'b1; tick(3);
    rst_n = 1'b1; cmd_ready = 1'b1;
    tick(2 * C);
    base = got.size();
    send_byte(8'h64, 1, 1, C);
    chk("arst_nopend", got.size(), base);
    send_byte(8'h90, 1, 1, 0);
    send_byte(8'h64, 1, 1, C);
    chk("arst_cnt", got.size(), base + 1);
    if (got.size() > base) chk("arst_cmd", got[base], {7'h10, 7'h64});

    exp_q.delete();
    base = got.size(); f0 = ferr_cnt; o0 = ovr_cnt; m_ferr = 0;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      pg = ($urandom_range(0, 7) != 0);
      send_byte(b, stop, pg, (!stop || (PAR && !pg)) ? 2 * C : int'($urandom_range(0, C)));
    end
    tick(C);
    chk("rand_cnt", got.size() - base, exp_q.size());
    n = exp_q.size();
    for (int i = 0; i < n; i++)
      if (base + i < got.size()) chk("rand_cmd", got[base + i], exp_q[i]);
    chk("rand_ferr", ferr_cnt - f0, m_ferr);
    chk("rand_ovr", ovr_cnt - o0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
